bpu_btb: RTL

//  Parametrised branch target buffer with saturating-counter direction predictor for the IF stage.

---
 rtl/bpu_btb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bpu_btb.sv
// Branch target buffer with per-entry saturating direction counters, mispredict
// detection/counting, and a one-entry-per-cycle invalidate sweep.
module bpu_btb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            update_en_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [XLEN-1:0] update_target_i,
  input  logic            update_is_jump_i,
  input  logic            update_pred_taken_i,
  input  logic [XLEN-1:0] update_pred_tgt_i,
  output logic            mispred_o,
  output logic [31:0]     mispred_cnt_o,
  input  logic            inv_req_i,
  output logic            busy_o
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_W  = XLEN - IDX_W - 2;
  localparam int unsigned WT_INT = 1 << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(WT_INT);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(WT_INT - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic             sweep_clr;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit, upd_accept;
  logic [CNT_W-1:0] u_cnt, cnt_inc, cnt_dec;
  logic             unused_lsbs;

  assign unused_lsbs = ^update_pc_i[1:0];

  assign l_idx = lookup_pc_i[IDX_W+1:2];
  assign l_tag = lookup_pc_i[XLEN-1:IDX_W+2];
  assign u_idx = update_pc_i[IDX_W+1:2];
  assign u_tag = update_pc_i[XLEN-1:IDX_W+2];

  assign busy_o        = (state == SWEEP);
  assign pred_hit_o    = valid[l_idx] & (tag_q[l_idx] == l_tag) & ~busy_o;
  assign pred_taken_o  = pred_hit_o & (jump_q[l_idx] | cnt_q[l_idx][CNT_W-1]);
  assign pred_target_o = pred_taken_o ? tgt_q[l_idx] : lookup_pc_i + XLEN'(4);

  assign mispred_o = update_en_i &
                     ((update_taken_i != update_pred_taken_i) |
                      (update_taken_i & (update_target_i != update_pred_tgt_i)));

  assign upd_accept = update_en_i & ~busy_o;
  assign u_hit      = valid[u_idx] & (tag_q[u_idx] == u_tag);
  assign u_cnt      = cnt_q[u_idx];
  assign cnt_inc    = (u_cnt == CNT_MAX) ? CNT_MAX : u_cnt + CNT_W'(1);
  assign cnt_dec    = (u_cnt == '0) ? '0 : u_cnt - CNT_W'(1);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sweep_clr = 1'b0;
    case (state)
      IDLE: begin
        if (inv_req_i) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        if (ptr == IDX_W'(ENTRIES - 1)) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Sweep clears and accepted updates never coincide: updates are dropped while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
    end else begin
      if (sweep_clr) valid[ptr] <= 1'b0;
      if (upd_accept) begin
        if (u_hit) begin
          cnt_q[u_idx] <= update_taken_i ? cnt_inc : cnt_dec;
        end else if (update_taken_i) begin
          valid[u_idx] <= 1'b1;
          cnt_q[u_idx] <= CNT_WT;
        end
      end
    end
  end

  // Payload fields are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_accept && (u_hit || update_taken_i)) begin
      jump_q[u_idx] <= update_is_jump_i;
      if (update_taken_i) begin
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= update_target_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mispred_cnt_o <= '0;
    else if (mispred_o) mispred_cnt_o <= mispred_cnt_o + 32'd1;
  end

endmodule
